// File: rtl/ni_packetizer_pkg.sv
// Shared NoC definitions: node positions, router directions, flit format and
// head-flit payload layout. The router and the packetizer both use these.
package ni_packetizer_pkg;

  localparam int COORD_W    = 2;
  localparam int NOC_DATA_W = 32;
  localparam int HEAD_LEN_W = 8;

  typedef struct packed {
    logic [COORD_W-1:0] x;
    logic [COORD_W-1:0] y;
    logic [COORD_W-1:0] z;
  } position_t;

  typedef enum logic [2:0] {
    DIR_LOCAL = 3'd0,
    DIR_XP    = 3'd1,
    DIR_XN    = 3'd2,
    DIR_YP    = 3'd3,
    DIR_YN    = 3'd4,
    DIR_ZP    = 3'd5,
    DIR_ZN    = 3'd6
  } direction_e;

  typedef enum logic [1:0] {
    HEAD     = 2'd0,
    BODY     = 2'd1,
    TAIL     = 2'd2,
    HEADTAIL = 2'd3
  } flit_type_e;

  typedef struct packed {
    flit_type_e              ftype;
    logic [NOC_DATA_W-1:0]   payload;
  } flit_t;

  // dest sits in the LSBs so route computation reads a fixed field
  typedef struct packed {
    logic [HEAD_LEN_W-1:0] len;
    position_t             src;
    position_t             dest;
  } head_payload_t;

  function automatic logic [NOC_DATA_W-1:0] pack_head(head_payload_t h);
    return NOC_DATA_W'(h);
  endfunction

  function automatic head_payload_t unpack_head(logic [NOC_DATA_W-1:0] p);
    return head_payload_t'(p[$bits(head_payload_t)-1:0]);
  endfunction

endpackage

// File: rtl/ni_packetizer_if.sv
// Request, payload, flit and credit signals between a traffic source, the
// packetizer and the local router input port.
interface ni_packetizer_if
  import ni_packetizer_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int LEN_W  = 4
);
  logic              req_valid;
  logic              req_ready;
  position_t         req_dest;
  logic [LEN_W-1:0]  req_len;
  logic              pld_valid;
  logic              pld_ready;
  logic [DATA_W-1:0] pld_data;
  logic              flit_valid;
  flit_t             flit;
  logic              credit_in;
  logic              busy;

  modport slave (
    input  req_valid, req_dest, req_len, pld_valid, pld_data, credit_in,
    output req_ready, pld_ready, flit_valid, flit, busy
  );

  modport master (
    output req_valid, req_dest, req_len, pld_valid, pld_data, credit_in,
    input  req_ready, pld_ready, flit_valid, flit, busy
  );
endinterface

// File: rtl/ni_credit_counter.sv
// Tracks free slots in the downstream router input buffer. Starts full,
// drops on every flit issued, rises on every returned credit.
module ni_credit_counter #(
  parameter  int CREDITS = 4,
  localparam int CNT_W   = $clog2(CREDITS+1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  input  logic             dec,
  output logic             avail,
  output logic [CNT_W-1:0] count
);

  assign avail = (count != '0);

  // Credit register; a simultaneous issue and return cancel out, and a
  // return while already full is flagged and ignored
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= CNT_W'(CREDITS);
    end else begin
      assert (!(inc && !dec && count == CNT_W'(CREDITS)))
        else $warning("ni_credit_counter: credit returned while counter already full");
      assert (!(dec && count == '0))
        else $error("ni_credit_counter: issue with no credit available");
      if (inc && !dec && count != CNT_W'(CREDITS))
        count <= count + CNT_W'(1);
      else if (dec && !inc)
        count <= count - CNT_W'(1);
    end
  end

endmodule

// File: rtl/ni_packetizer.sv
// Network-interface injection side: turns a (dest, len, payload stream)
// request into a HEAD/BODY/TAIL wormhole packet under credit flow control.
module ni_packetizer
  import ni_packetizer_pkg::*;
#(
  parameter  position_t POS      = '0,
  parameter  int        DATA_W   = NOC_DATA_W,
  parameter  int        MAX_BODY = 15,
  parameter  int        CREDITS  = 4,
  localparam int        LEN_W    = $clog2(MAX_BODY+1),
  localparam int        CNT_W    = $clog2(CREDITS+1)
) (
  input logic           clk,
  input logic           rst,
  ni_packetizer_if.slave bus
);

  if (DATA_W < LEN_W + 2*$bits(position_t)) begin : g_bad_width
    $fatal(1, "ni_packetizer: DATA_W too small for head payload");
  end
  if (DATA_W != NOC_DATA_W || LEN_W > HEAD_LEN_W) begin : g_bad_fmt
    $fatal(1, "ni_packetizer: DATA_W/LEN_W incompatible with shared flit format");
  end

  typedef enum logic [1:0] {S_IDLE, S_HEAD, S_BODY} state_e;

  state_e           state_q, state_d;
  logic [LEN_W-1:0] len_q, rem_q;
  position_t        dest_q;
  logic             issue;
  logic             avail;
  flit_t            flit_d;
  head_payload_t    head_pl;
  logic [CNT_W-1:0] credit_cnt;

  ni_credit_counter #(.CREDITS(CREDITS)) u_credit (
    .clk   (clk),
    .rst   (rst),
    .inc   (bus.credit_in),
    .dec   (issue),
    .avail (avail),
    .count (credit_cnt)
  );

  assign head_pl.len  = HEAD_LEN_W'(len_q);
  assign head_pl.src  = POS;
  assign head_pl.dest = dest_q;
  assign bus.busy     = (state_q != S_IDLE);

  // Next state, handshakes and the flit to issue this cycle
  always_comb begin
    state_d       = state_q;
    issue         = 1'b0;
    flit_d        = '0;
    bus.req_ready = 1'b0;
    bus.pld_ready = 1'b0;
    case (state_q)
      S_IDLE: begin
        bus.req_ready = 1'b1;
        if (bus.req_valid) state_d = S_HEAD;
      end
      S_HEAD: begin
        if (avail) begin
          issue          = 1'b1;
          flit_d.ftype   = (len_q == '0) ? HEADTAIL : HEAD;
          flit_d.payload = pack_head(head_pl);
          state_d        = (len_q == '0) ? S_IDLE : S_BODY;
        end
      end
      S_BODY: begin
        if (bus.pld_valid && avail) begin
          bus.pld_ready  = 1'b1;
          issue          = 1'b1;
          flit_d.ftype   = (rem_q == LEN_W'(1)) ? TAIL : BODY;
          flit_d.payload = NOC_DATA_W'(bus.pld_data);
          if (rem_q == LEN_W'(1)) state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // Request capture and remaining-body counter
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      len_q  <= '0;
      dest_q <= '0;
      rem_q  <= '0;
    end else begin
      if (state_q == S_IDLE && bus.req_valid) begin
        assert (bus.req_len <= LEN_W'(MAX_BODY))
          else $error("ni_packetizer: req_len exceeds MAX_BODY");
        len_q  <= bus.req_len;
        dest_q <= bus.req_dest;
      end
      if (state_q == S_HEAD && issue)
        rem_q <= len_q;
      else if (state_q == S_BODY && issue)
        rem_q <= rem_q - LEN_W'(1);
    end
  end

  // Registered flit output, valid for exactly one cycle per issue
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.flit_valid <= 1'b0;
      bus.flit       <= '0;
    end else begin
      bus.flit_valid <= issue;
      if (issue) bus.flit <= flit_d;
    end
  end

endmodule
